axis_packet_arbiter: RTL and testbench

Parametrised N-input AXI-Stream packet multiplexer for the MII MAC transmit path: merges several packet sources (e.g. user TX, ARP/ICMP responders, pause-frame generator) onto one MAC-facing stream. Arbitration is packet-atomic: once a source is granted, its beats pass until its `tlast` beat is accepted. Fixed-priority or round-robin selection is set by a parameter. A single registered output stage gives one-cycle latency and full throughput within a packet.

---
 rtl/axis_packet_arbiter.sv | 129 ++++++++++++
 tb/tb_axis_packet_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_arbiter.sv
// N-input AXI-Stream packet multiplexer. A granted source keeps the output
// until its tlast beat is accepted; selection is fixed priority or round robin.
// One registered output stage gives one-cycle latency and full in-packet rate.
module axis_packet_arbiter #(
  parameter int NUM_INPUTS = 4,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1,
  parameter int ARB_MODE   = 1,
  parameter int IDX_WIDTH  = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             clock,
  input  logic                             aresetn,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] saxis_tdata,
  input  logic [NUM_INPUTS-1:0]            saxis_tvalid,
  output logic [NUM_INPUTS-1:0]            saxis_tready,
  input  logic [NUM_INPUTS*USER_WIDTH-1:0] saxis_tuser,
  input  logic [NUM_INPUTS-1:0]            saxis_tlast,
  output logic [DATA_WIDTH-1:0]            maxis_tdata,
  output logic                             maxis_tvalid,
  input  logic                             maxis_tready,
  output logic [USER_WIDTH-1:0]            maxis_tuser,
  output logic                             maxis_tlast,
  output logic [IDX_WIDTH-1:0]             maxis_tdest,
  output logic                             busy
);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t               state;
  logic [IDX_WIDTH-1:0] grant;
  logic [IDX_WIDTH-1:0] rr_ptr;
  logic [IDX_WIDTH-1:0] winner;
  logic [IDX_WIDTH-1:0] rr_next;
  logic                 out_free;
  logic                 acc;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_last;

  // Output register can take a beat when empty or draining this cycle.
  assign out_free = !maxis_tvalid || maxis_tready;
  assign busy     = (state == ACTIVE);

  // Only the granted channel sees ready; no path from any tvalid.
  for (genvar i = 0; i < NUM_INPUTS; i++) begin : g_rdy
    assign saxis_tready[i] = (state == ACTIVE) && (grant == IDX_WIDTH'(i)) && out_free;
  end

  // Ready is one-hot, so any handshake is the granted channel's.
  assign acc = |(saxis_tvalid & saxis_tready);

  assign rr_next = (grant == IDX_WIDTH'(NUM_INPUTS - 1)) ? '0 : grant + 1'b1;

  // Winner search: from rr_ptr upward then wrap (fixed priority starts at 0).
  always_comb begin
    int   base;
    logic found;
    winner = '0;
    found  = 1'b0;
    base   = (ARB_MODE == 1) ? int'(rr_ptr) : 0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && (i >= base) && saxis_tvalid[i]) begin
        winner = IDX_WIDTH'(i);
        found  = 1'b1;
      end
    end
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (!found && (i < base) && saxis_tvalid[i]) begin
        winner = IDX_WIDTH'(i);
        found  = 1'b1;
      end
    end
  end

  // Steer the granted channel's payload toward the output register.
  always_comb begin
    sel_data = '0;
    sel_user = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (grant == IDX_WIDTH'(i)) begin
        sel_data = saxis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        sel_user = saxis_tuser[i*USER_WIDTH +: USER_WIDTH];
        sel_last = saxis_tlast[i];
      end
    end
  end

  // Arbitration FSM plus output register; a load wins over a drain.
  always_ff @(posedge clock) begin
    if (!aresetn) begin
      state        <= IDLE;
      grant        <= '0;
      rr_ptr       <= '0;
      maxis_tvalid <= 1'b0;
      maxis_tdata  <= '0;
      maxis_tuser  <= '0;
      maxis_tlast  <= 1'b0;
      maxis_tdest  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|saxis_tvalid) begin
            grant <= winner;
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (acc && sel_last) begin
            state <= IDLE;
            if (ARB_MODE == 1) rr_ptr <= rr_next;
          end
        end
        default: state <= IDLE;
      endcase

      if (acc) begin
        maxis_tvalid <= 1'b1;
        maxis_tdata  <= sel_data;
        maxis_tuser  <= sel_user;
        maxis_tlast  <= sel_last;
        maxis_tdest  <= grant;
      end else if (maxis_tvalid && maxis_tready) begin
        maxis_tvalid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_axis_packet_arbiter.sv
// Directed bench: a round-robin and a fixed-priority instance share the same
// source stimulus; sources advance on the round-robin instance's handshakes.
module tb_axis_packet_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int UW = 1;
  localparam int IW = 2;

  logic clock = 1'b0;
  logic aresetn = 1'b0;
  always #5 clock = ~clock;

  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    s_tvalid;
  logic [N-1:0]    s_tlast;
  logic [N*UW-1:0] s_tuser;
  logic            m_tready;

  logic [N-1:0]  rr_tready, fp_tready;
  logic [DW-1:0] rr_tdata, fp_tdata;
  logic [UW-1:0] rr_tuser, fp_tuser;
  logic          rr_tvalid, fp_tvalid, rr_tlast, fp_tlast, rr_busy, fp_busy;
  logic [IW-1:0] rr_tdest, fp_tdest;

  axis_packet_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ARB_MODE(1)) u_rr (
    .clock(clock), .aresetn(aresetn),
    .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(rr_tready),
    .saxis_tuser(s_tuser), .saxis_tlast(s_tlast),
    .maxis_tdata(rr_tdata), .maxis_tvalid(rr_tvalid), .maxis_tready(m_tready),
    .maxis_tuser(rr_tuser), .maxis_tlast(rr_tlast), .maxis_tdest(rr_tdest), .busy(rr_busy));

  axis_packet_arbiter #(.NUM_INPUTS(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .ARB_MODE(0)) u_fp (
    .clock(clock), .aresetn(aresetn),
    .saxis_tdata(s_tdata), .saxis_tvalid(s_tvalid), .saxis_tready(fp_tready),
    .saxis_tuser(s_tuser), .saxis_tlast(s_tlast),
    .maxis_tdata(fp_tdata), .maxis_tvalid(fp_tvalid), .maxis_tready(m_tready),
    .maxis_tuser(fp_tuser), .maxis_tlast(fp_tlast), .maxis_tdest(fp_tdest), .busy(fp_busy));

  typedef struct {
    logic [IW-1:0] dest;
    logic [DW-1:0] data;
    logic          user;
    logic          last;
    int            cyc;
  } beat_t;

  beat_t         out_q[$];
  logic [IW-1:0] fp_q[$];

  logic [7:0] src_data [N][8];
  logic       src_last [N][8];
  int         src_len  [N];
  int         src_ptr  [N];
  logic       src_en   [N];
  logic       src_loop [N];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit bp_mode = 0;
  bit bp_chk = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_src();
    for (int ch = 0; ch < N; ch++) begin
      logic v;
      v = src_en[ch] && (src_ptr[ch] < src_len[ch]);
      s_tvalid[ch]         = v;
      s_tdata[ch*DW +: DW] = v ? src_data[ch][src_ptr[ch] % 8] : 8'h00;
      s_tuser[ch]          = v ? src_data[ch][src_ptr[ch] % 8][0] : 1'b0;
      s_tlast[ch]          = v ? src_last[ch][src_ptr[ch] % 8] : 1'b0;
    end
  endtask

  task automatic load(input int ch, input int len, input logic [7:0] base, input bit all_last);
    for (int k = 0; k < len; k++) begin
      src_data[ch][k] = base + 8'(k);
      src_last[ch][k] = all_last || (k == len - 1);
    end
    src_len[ch]  = len;
    src_ptr[ch]  = 0;
    src_en[ch]   = 1'b1;
    src_loop[ch] = 1'b0;
  endtask

  // One clock: sample handshakes at the falling edge, update sources after the rising edge.
  task automatic cycle();
    logic [N-1:0] acc;
    beat_t b;
    @(negedge clock);
    acc = s_tvalid & rr_tready;
    if (rr_tvalid && m_tready) begin
      b.dest = rr_tdest; b.data = rr_tdata; b.user = rr_tuser[0]; b.last = rr_tlast; b.cyc = cyc;
      out_q.push_back(b);
    end
    if (fp_tvalid && m_tready) fp_q.push_back(fp_tdest);
    if (bp_chk && rr_tvalid && !m_tready) chk("bp_ready_low", 32'(rr_tready[1]), 0);
    @(posedge clock);
    #1;
    cyc++;
    for (int ch = 0; ch < N; ch++) begin
      if (acc[ch]) begin
        src_ptr[ch]++;
        if (src_loop[ch] && src_ptr[ch] >= src_len[ch]) src_ptr[ch] = 0;
      end
    end
    m_tready = bp_mode ? ((cyc % 3) == 0) : 1'b1;
    drive_src();
  endtask

  task automatic do_reset();
    for (int ch = 0; ch < N; ch++) begin
      src_en[ch] = 1'b0; src_len[ch] = 0; src_ptr[ch] = 0; src_loop[ch] = 1'b0;
    end
    m_tready = 1'b1;
    drive_src();
    aresetn = 1'b0;
    cycle();
    cycle();
    aresetn = 1'b1;
    out_q.delete();
    fp_q.delete();
  endtask

  function automatic bit srcs_done();
    bit d;
    d = 1'b1;
    for (int ch = 0; ch < N; ch++) if (src_ptr[ch] < src_len[ch]) d = 1'b0;
    return d;
  endfunction

  task automatic run_until_idle(input string tag, input int max);
    int n;
    n = 0;
    while (!(srcs_done() && !rr_busy && !rr_tvalid) && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < max), 1);
  endtask

  task automatic run_until_ptr(input string tag, input int ch, input int v, input int max);
    int n;
    n = 0;
    while (src_ptr[ch] != v && n < max) begin
      cycle();
      n++;
    end
    chk({tag, "_timeout"}, 32'(n < max), 1);
  endtask

  task automatic chk_beat(input string tag, input int i, input int dest, input int data, input int last);
    if (i < out_q.size()) begin
      chk({tag, "_dest"}, 32'(out_q[i].dest), dest);
      chk({tag, "_data"}, 32'(out_q[i].data), data);
      chk({tag, "_user"}, 32'(out_q[i].user), data % 2);
      chk({tag, "_last"}, 32'(out_q[i].last), last);
    end else begin
      chk({tag, "_present"}, 32'(out_q.size()), 32'(i + 1));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    m_tready = 1'b1;
    do_reset();

    // Reset state
    chk("rst_tvalid", 32'(rr_tvalid), 0);
    chk("rst_tdata",  32'(rr_tdata), 0);
    chk("rst_tdest",  32'(rr_tdest), 0);
    chk("rst_tlast",  32'(rr_tlast), 0);
    chk("rst_busy",   32'(rr_busy), 0);
    chk("rst_tready", 32'(rr_tready), 0);
    chk("rst_fp_tvalid", 32'(fp_tvalid), 0);

    // Fixed priority: ch0 before ch2, one idle cycle between packets
    load(2, 3, 8'h10, 0);
    load(0, 3, 8'h20, 0);
    drive_src();
    run_until_idle("t1", 40);
    chk("t1_count", 32'(out_q.size()), 6);
    for (int i = 0; i < 3; i++) chk_beat("t1_ch0", i, 0, 8'h20 + i, (i == 2) ? 1 : 0);
    for (int i = 0; i < 3; i++) chk_beat("t1_ch2", i + 3, 2, 8'h10 + i, (i == 2) ? 1 : 0);
    if (out_q.size() >= 4) chk("t1_gap", 32'(out_q[3].cyc - out_q[2].cyc), 2);
    chk("t1_fp_count", 32'(fp_q.size()), 6);
    if (fp_q.size() >= 4) begin
      chk("t1_fp_first", 32'(fp_q[0]), 0);
      chk("t1_fp_second", 32'(fp_q[3]), 2);
    end

    // Round robin with all channels continuously offering 2-beat packets
    do_reset();
    for (int ch = 0; ch < N; ch++) begin
      load(ch, 2, 8'h40 + 8'(ch * 16), 0);
      src_loop[ch] = 1'b1;
    end
    drive_src();
    repeat (22) cycle();
    chk("t2_enough", 32'(out_q.size() >= 12), 1);
    for (int i = 0; i < 12; i++)
      chk_beat("t2_rr", i, (i / 2) % 4, 8'h40 + ((i / 2) % 4) * 16 + (i % 2), i % 2);
    chk("t2_fp_enough", 32'(fp_q.size() >= 8), 1);
    for (int i = 0; i < 8 && i < fp_q.size(); i++) chk("t2_fp_dest", 32'(fp_q[i]), 0);

    // Backpressure on a 5-beat ch1 packet
    do_reset();
    load(1, 5, 8'hA0, 0);
    drive_src();
    bp_mode = 1;
    bp_chk = 1;
    run_until_idle("t3", 60);
    bp_mode = 0;
    bp_chk = 0;
    m_tready = 1'b1;
    chk("t3_count", 32'(out_q.size()), 5);
    for (int i = 0; i < 5; i++) chk_beat("t3_bp", i, 1, 8'hA0 + i, (i == 4) ? 1 : 0);

    // Source stall: ch0 drops valid mid-packet while ch3 waits
    do_reset();
    load(0, 4, 8'h50, 0);
    load(3, 2, 8'h60, 0);
    drive_src();
    run_until_ptr("t4", 0, 2, 20);
    src_en[0] = 1'b0;
    drive_src();
    repeat (4) begin
      cycle();
      chk("t4_ch3_ready", 32'(rr_tready[3]), 0);
      chk("t4_fp_ch3_ready", 32'(fp_tready[3]), 0);
      chk("t4_busy", 32'(rr_busy), 1);
    end
    src_en[0] = 1'b1;
    drive_src();
    run_until_idle("t4", 40);
    chk("t4_count", 32'(out_q.size()), 6);
    for (int i = 0; i < 4; i++) chk_beat("t4_ch0", i, 0, 8'h50 + i, (i == 3) ? 1 : 0);
    for (int i = 0; i < 2; i++) chk_beat("t4_ch3", i + 4, 3, 8'h60 + i, (i == 1) ? 1 : 0);

    // Reset during the 3rd beat of a ch1 packet
    do_reset();
    load(1, 5, 8'h70, 0);
    drive_src();
    run_until_ptr("t5", 1, 2, 20);
    aresetn = 1'b0;
    cycle();
    chk("t5_tvalid", 32'(rr_tvalid), 0);
    chk("t5_busy",   32'(rr_busy), 0);
    chk("t5_tready", 32'(rr_tready), 0);
    chk("t5_rr_ptr", 32'(u_rr.rr_ptr), 0);
    chk("t5_tdata",  32'(rr_tdata), 0);
    aresetn = 1'b1;
    src_len[1] = 0;
    out_q.delete();
    fp_q.delete();
    load(0, 2, 8'h80, 0);
    drive_src();
    run_until_idle("t5", 20);
    chk("t5_count", 32'(out_q.size()), 2);
    for (int i = 0; i < 2; i++) chk_beat("t5_ch0", i, 0, 8'h80 + i, i);

    // Back-to-back single-beat packets on ch3
    do_reset();
    load(3, 3, 8'h90, 1);
    drive_src();
    run_until_idle("t6", 30);
    chk("t6_count", 32'(out_q.size()), 3);
    for (int i = 0; i < 3; i++) chk_beat("t6_single", i, 3, 8'h90 + i, 1);
    if (out_q.size() >= 3) begin
      chk("t6_gap1", 32'(out_q[1].cyc - out_q[0].cyc), 2);
      chk("t6_gap2", 32'(out_q[2].cyc - out_q[1].cyc), 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
